intg_result_fifo: RTL and testbench

Downstream stage of the integrator (`INTG`). It captures each completed 13-bit integration result `Y` on a window-done strobe, tags it against a programmable threshold, and buffers it in a small first-word-fall-through FIFO. Results are presented to the consumer over a valid/ready handshake. Overflow is counted, never silently lost.

---
 rtl/intg_pkg.sv | 14 +
 rtl/intg_result_fifo_if.sv | 28 ++
 rtl/intg_fifo_mem.sv | 23 ++
 rtl/intg_result_fifo.sv | 91 +++++++++
 tb/tb_intg_result_fifo.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/intg_pkg.sv
// Shared integrator definitions: result width, coefficient, window length and
// the buffered result entry layout used downstream of the integrator.
package intg_pkg;

    localparam int INTG_DATA_W = 13;
    localparam int INTG_COEF   = 25;
    localparam int INTG_WIN    = 4;

    typedef struct packed {
        logic                   over;
        logic [INTG_DATA_W-1:0] data;
    } intg_entry_t;

endpackage

// File: rtl/intg_result_fifo_if.sv
// Result stream between the integrator/consumer side and intg_result_fifo.
// The FIFO is the slave; whoever produces Y and consumes out_* is the master.
interface intg_result_fifo_if #(
    parameter int DATA_W = 13,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
);
    logic [DATA_W-1:0]        Y;
    logic                     y_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     out_over;
    logic                     out_valid;
    logic [$clog2(DEPTH):0]   count;
    logic                     full;
    logic                     empty;
    logic [DROP_W-1:0]        drop_cnt;

    modport master (
        output Y, y_valid, out_ready,
        input  out_data, out_over, out_valid, count, full, empty, drop_cnt
    );

    modport slave (
        input  Y, y_valid, out_ready,
        output out_data, out_over, out_valid, count, full, empty, drop_cnt
    );
endinterface

// File: rtl/intg_fifo_mem.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read
// port so the head entry falls through without a read cycle.
module intg_fifo_mem #(
    parameter int W     = 14,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; occupancy lives in the pointers/count, so stale
    // words are never observed and the array stays a plain register file.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/intg_result_fifo.sv
// Captures integrator results on y_valid, tags them against THRESH and buffers
// them in a first-word-fall-through FIFO with a saturating overflow counter.
module intg_result_fifo
    import intg_pkg::*;
#(
    parameter int                DATA_W = INTG_DATA_W,
    parameter int                DEPTH  = 4,
    parameter logic [DATA_W-1:0] THRESH = DATA_W'(1000),
    parameter int                DROP_W = 8
) (
    input logic              CLK,
    input logic              RST,
    intg_result_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [DROP_W-1:0] drop_q,   drop_d;

    logic              full, empty, out_valid;
    logic              push, pop, drop;
    logic [DATA_W:0]   wr_entry, rd_entry;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign out_valid = !empty;

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    assign pop  = out_valid && bus.out_ready;
    assign push = bus.y_valid && (!full || pop);
    assign drop = bus.y_valid && full && !pop;

    // Unsigned compare; the flag is frozen into the entry at push time.
    assign wr_entry = {bus.Y > THRESH, bus.Y};

    // NOTE: every next-state signal gets its hold value first, so no path through
    // this block can leave one unassigned and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (drop && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    intg_fifo_mem #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (CLK),
        .we_i    (push && RST),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    assign bus.out_data  = rd_entry[DATA_W-1:0];
    assign bus.out_over  = rd_entry[DATA_W];
    assign bus.out_valid = out_valid;
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_intg_result_fifo.sv
// Randomized self-checking bench for intg_result_fifo against a queue-based
// reference model of the FIFO, threshold flag and saturating drop counter.
module tb_intg_result_fifo;
    import intg_pkg::*;

    localparam int DATA_W = 13;
    localparam int DEPTH  = 4;
    localparam int DROP_W = 8;
    localparam int THRESH = 1000;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic CLK = 1'b0;
    logic RST;

    intg_result_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

    intg_result_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .THRESH (DATA_W'(THRESH)),
        .DROP_W (DROP_W)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: a queue of {over, value} plus the drop count.
    int unsigned m_data[$];
    bit          m_over[$];
    int          m_drops = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        int n;
        n = m_data.size();
        check({tag, ".count"},     32'(bus.count),     32'(n));
        check({tag, ".empty"},     32'(bus.empty),     32'(n == 0));
        check({tag, ".full"},      32'(bus.full),      32'(n == DEPTH));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(n != 0));
        check({tag, ".drop_cnt"},  32'(bus.drop_cnt),  32'(m_drops));
        if (n != 0) begin
            check({tag, ".out_data"}, 32'(bus.out_data), m_data[0]);
            check({tag, ".out_over"}, 32'(bus.out_over), 32'(m_over[0]));
        end
    endtask

    // Called at a negedge: drive inputs, advance the model across the posedge,
    // then compare at the following negedge.
    task automatic cycle(input bit yv, input int unsigned y, input bit rdy, input bit rst_n,
                         input string tag);
        bit pop, push, is_full;
        bus.y_valid   = yv;
        bus.Y         = DATA_W'(y);
        bus.out_ready = rdy;
        RST           = rst_n;
        @(posedge CLK);
        if (!rst_n) begin
            m_data.delete();
            m_over.delete();
            m_drops = 0;
        end else begin
            is_full = (m_data.size() == DEPTH);
            pop     = (m_data.size() != 0) && rdy;
            push    = yv && (!is_full || pop);
            if (pop) begin
                void'(m_data.pop_front());
                void'(m_over.pop_front());
            end
            if (push) begin
                m_data.push_back(y);
                m_over.push_back(y > THRESH);
            end
            if (yv && is_full && !pop && m_drops < DROP_MAX) m_drops++;
        end
        @(negedge CLK);
        check_outputs(tag);
    endtask

    initial begin
        RST           = 1'b0;
        bus.y_valid   = 1'b0;
        bus.Y         = '0;
        bus.out_ready = 1'b0;
        @(negedge CLK);

        // Reset then idle
        cycle(0, 0, 0, 0, "rst0");
        cycle(0, 0, 0, 0, "rst1");
        cycle(0, 0, 0, 1, "idle");

        // Single pass-through
        cycle(1, 700, 1, 1, "pass_in");
        cycle(0, 0,   1, 1, "pass_out");

        // Fill and drain in order, including one flagged entry
        cycle(1, 700,  0, 1, "fill0");
        cycle(1, 775,  0, 1, "fill1");
        cycle(1, 1100, 0, 1, "fill2");
        cycle(1, 550,  0, 1, "fill3");
        cycle(0, 0,    0, 1, "hold");
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 1, "drain");

        // Overflow and drop-counter saturation
        for (int i = 0; i < 4; i++) cycle(1, 900 + i, 0, 1, "refill");
        for (int i = 0; i < 3; i++) cycle(1, 1500, 0, 1, "drop3");
        for (int i = 0; i < 260; i++) cycle(1, 1500, 0, 1, "drop_sat");

        // Full with simultaneous push/pop: no drop, count stays DEPTH
        cycle(1, 1001, 1, 1, "full_pushpop");
        cycle(1, 1000, 1, 1, "full_pushpop_eq");

        // Continuous stream at full rate with out_ready held high
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1, "empty_out");
        for (int i = 0; i < 40; i++) cycle(1, $urandom_range(0, 8191), 1, 1, "stream");
        cycle(0, 0, 1, 1, "stream_end");

        // Reset mid-stream with a strobe and ready in the same cycle
        cycle(0, 0, 1, 1, "pre_mid");
        for (int i = 0; i < 3; i++) cycle(1, 1200 + i, 0, 1, "mid_fill");
        cycle(1, 4000, 1, 0, "mid_rst");
        cycle(0, 0, 0, 1, "mid_after");

        // Randomized traffic with values clustered around the threshold
        for (int i = 0; i < 2000; i++) begin
            int unsigned y;
            case ($urandom_range(0, 3))
                0:       y = THRESH - 1 + $urandom_range(0, 2);
                1:       y = $urandom_range(0, 8191);
                2:       y = (i % 2) ? 8191 : 0;
                default: y = $urandom_range(900, 1100);
            endcase
            cycle($urandom_range(0, 99) < 60, y, $urandom_range(0, 99) < 45,
                  $urandom_range(0, 299) != 0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
